// File: rtl/test_system_sb_rst_pkg.sv
// rtl/test_system_sb_rst_pkg.sv - shared types and widths for the lock-driven reset sequencer
package test_system_sb_rst_pkg;

  localparam int LOSS_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rst_state_e;

  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/test_system_sb_sync2.sv
// rtl/test_system_sb_sync2.sv - two-flop synchronizer, async active-low reset to 0
module test_system_sb_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/test_system_sb_lock_rst_ctrl.sv
// rtl/test_system_sb_lock_rst_ctrl.sv - releases fabric then peripheral reset once CCC lock is stable
module test_system_sb_lock_rst_ctrl
  import test_system_sb_rst_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       LOCK,
  input  logic       SOFT_RESET,
  input  logic       CLEAR_LOST,
  output logic       LOCK_SYNC,
  output logic       FABRIC_RESET_N,
  output logic       PERIPH_RESET_N,
  output logic       INIT_DONE,
  output logic       LOCK_LOST,
  output logic [7:0] LOSS_COUNT,
  output logic [1:0] STATE
);

  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LIM    = CNT_W'(GAP_CYCLES);

  logic              lock_sync;
  rst_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              fabric_q, fabric_d;
  logic              periph_q, periph_d;
  logic              init_q, init_d;
  logic              lost_q, lost_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic              loss_evt;

  test_system_sb_sync2 u_lock_sync (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (LOCK),
    .q_o    (lock_sync)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      fabric_q   <= 1'b0;
      periph_q   <= 1'b0;
      init_q     <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fabric_q   <= fabric_d;
      periph_q   <= periph_d;
      init_q     <= init_d;
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  // The WAIT_LOCK->STABLE edge already counts as the first stable cycle,
  // so cnt_q is always 0 in WAIT_LOCK and cnt_inc is the running total.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + CNT_W'(1);
    loss_evt = !lock_sync && (state_q == RELEASE || state_q == RUN);

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_sync) begin
          if (cnt_inc >= STABLE_LIM) begin
            state_d = RELEASE;
          end else begin
            state_d = STABLE;
            cnt_d   = cnt_inc;
          end
        end
      end
      STABLE: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_inc >= STABLE_LIM) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        if (cnt_inc >= GAP_LIM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    if (loss_evt || SOFT_RESET) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    fabric_d   = (state_d == RELEASE) || (state_d == RUN);
    periph_d   = (state_d == RUN);
    init_d     = (state_d == RUN);
    lost_d     = lost_q;
    loss_cnt_d = loss_cnt_q;
    if (loss_evt) begin
      lost_d     = 1'b1;
      loss_cnt_d = sat_inc(loss_cnt_q);
    end else if (CLEAR_LOST) begin
      lost_d = 1'b0;
    end
  end

  assign LOCK_SYNC      = lock_sync;
  assign FABRIC_RESET_N = fabric_q;
  assign PERIPH_RESET_N = periph_q;
  assign INIT_DONE      = init_q;
  assign LOCK_LOST      = lost_q;
  assign LOSS_COUNT     = loss_cnt_q;
  assign STATE          = state_q;

endmodule

// File: tb/tb_test_system_sb_lock_rst_ctrl.sv
// tb/tb_test_system_sb_lock_rst_ctrl.sv - bench for the lock-driven reset sequencer
module tb_test_system_sb_lock_rst_ctrl;

  localparam int S = 8;
  localparam int G = 4;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       LOCK = 1'b0;
  logic       SOFT_RESET = 1'b0;
  logic       CLEAR_LOST = 1'b0;
  logic       LOCK_SYNC, FABRIC_RESET_N, PERIPH_RESET_N, INIT_DONE, LOCK_LOST;
  logic [7:0] LOSS_COUNT;
  logic [1:0] STATE;

  int total = 0;
  int bad   = 0;

  // Reference: "up" counts consecutive synchronized-lock cycles since the
  // last restart, capped at S+G; every output follows from thresholds on it.
  int up    = 0;
  bit m_s1  = 0;
  bit m_ls  = 0;
  bit m_lost = 0;
  int m_cnt = 0;

  test_system_sb_lock_rst_ctrl #(.STABLE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .LOCK           (LOCK),
    .SOFT_RESET     (SOFT_RESET),
    .CLEAR_LOST     (CLEAR_LOST),
    .LOCK_SYNC      (LOCK_SYNC),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .PERIPH_RESET_N (PERIPH_RESET_N),
    .INIT_DONE      (INIT_DONE),
    .LOCK_LOST      (LOCK_LOST),
    .LOSS_COUNT     (LOSS_COUNT),
    .STATE          (STATE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [14:0] expv();
    logic [1:0] st;
    st = (up == 0) ? 2'd0 : (up < S) ? 2'd1 : (up < S + G) ? 2'd2 : 2'd3;
    return {m_ls, up >= S, up >= S + G, up >= S + G, m_lost, 8'(m_cnt), st};
  endfunction

  task automatic model_reset();
    up = 0; m_s1 = 0; m_ls = 0; m_lost = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit l, input bit s, input bit c);
    bit loss;
    loss = !m_ls && (up >= S);
    if (s || !m_ls) up = 0;
    else if (up < S + G) up++;
    if (loss) begin
      m_lost = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (c) begin
      m_lost = 0;
    end
    m_ls = m_s1;
    m_s1 = l;
  endtask

  task automatic check(input string tag);
    logic [14:0] obs, exp;
    obs = {LOCK_SYNC, FABRIC_RESET_N, PERIPH_RESET_N, INIT_DONE, LOCK_LOST, LOSS_COUNT, STATE};
    exp = expv();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit l, input bit s, input bit c, input string tag);
    LOCK = l; SOFT_RESET = s; CLEAR_LOST = c;
    @(posedge CLK);
    model_edge(l, s, c);
    #1;
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    RESET_N = 1'b0; SOFT_RESET = 1'b0; CLEAR_LOST = 1'b0;
    #1;
    model_reset();
    check(tag);
    repeat (2) @(posedge CLK);
    #1;
    check({tag, "_hold"});
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b1;
    #2;
    do_reset("por");

    for (int i = 0; i < 20; i++) cyc(0, 0, 0, "pwrup_idle");

    // Edge k is the first edge after LOCK rises.
    for (int i = 1; i <= 30; i++) begin
      cyc(1, 0, 0, "seq");
      if (i == 1)         chk1("lock_sync_k",    8'(LOCK_SYNC), 8'd0);
      if (i == 2)         chk1("lock_sync_k1",   8'(LOCK_SYNC), 8'd1);
      if (i == S + 1)     chk1("fabric_early",   8'(FABRIC_RESET_N), 8'd0);
      if (i == S + 2)     chk1("fabric_release", 8'(FABRIC_RESET_N), 8'd1);
      if (i == S + G + 1) chk1("init_early",     8'(INIT_DONE), 8'd0);
      if (i == S + G + 2) chk1("periph_release", 8'(PERIPH_RESET_N), 8'd1);
    end
    chk1("run_state", 8'(STATE), 8'd3);

    do_reset("rst2");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, "glitch_hi");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, "glitch_lo");
    chk1("glitch_no_loss", LOSS_COUNT, 8'd0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, "relock");

    cyc(0, 0, 0, "drop_k");
    cyc(0, 0, 0, "drop_k1");
    cyc(0, 0, 1, "drop_k2_clr");
    chk1("loss_resets_low", 8'({FABRIC_RESET_N, PERIPH_RESET_N}), 8'd0);
    chk1("set_beats_clear", 8'(LOCK_LOST), 8'd1);
    chk1("loss_count_1", LOSS_COUNT, 8'd1);
    cyc(0, 0, 1, "clear_alone");
    chk1("cleared", 8'(LOCK_LOST), 8'd0);

    for (int i = 0; i < 20; i++) cyc(1, 0, 0, "relock2");
    cyc(1, 1, 0, "soft_run");
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, "after_soft");

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 16; i++) cyc(1, 0, 0, "loop_hi");
      for (int i = 0; i < 3; i++)  cyc(0, 0, 0, "loop_lo");
    end
    chk1("loss_saturated", LOSS_COUNT, 8'd255);

    begin
      bit lv;
      int hold;
      lv = 0;
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
        if (hold == 0) begin
          lv = ~lv;
          hold = lv ? $urandom_range(1, 30) : $urandom_range(1, 6);
        end
        hold--;
        if ($urandom_range(0, 699) == 0) do_reset("rand_rst");
        cyc(lv, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, "rand");
      end
    end

    do_reset("rst3");
    for (int i = 0; i < S + 3; i++) cyc(1, 0, 0, "to_release");
    chk1("in_release", 8'(STATE), 8'd2);
    do_reset("rst_mid_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
